// File: rtl/sram_port_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one single-port SRAM.
// Data wins by default; starve_cnt forces an inst grant after STARVE_MAX data grants.
module sram_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [MEM_LAT-1:0] vld_q, vld_d;
    logic [MEM_LAT-1:0] own_inst_q, own_inst_d;
    logic [MEM_LAT-1:0] store_q, store_d;
    logic [CW-1:0]      starve_cnt_q, starve_cnt_d;

    logic busy;
    logic grant_inst;
    logic grant_data;
    logic ret_vld;
    logic ret_inst;
    logic ret_store;

    // Only the last pipe stage may be occupied when a new grant is issued.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < MEM_LAT - 1; i++) begin
            busy = busy | vld_q[i];
        end
    end

    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (resetn && !busy) begin
            if (inst_req && data_req) begin
                if (starve_cnt_q == CW'(STARVE_MAX)) begin
                    grant_inst = 1'b1;
                end else begin
                    grant_data = 1'b1;
                end
            end else begin
                grant_inst = inst_req;
                grant_data = data_req;
            end
        end
    end

    assign ret_vld   = resetn & vld_q[MEM_LAT-1];
    assign ret_inst  = own_inst_q[MEM_LAT-1];
    assign ret_store = store_q[MEM_LAT-1];

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign mem_en       = grant_inst | grant_data;
    assign mem_addr     = grant_inst ? inst_addr : (grant_data ? data_addr : 32'h0);
    assign mem_wen      = (grant_data && data_wr) ? data_wstrb : 4'h0;
    assign mem_wdata    = (grant_data && data_wr) ? data_wdata : 32'h0;

    assign inst_data_ok = ret_vld & ret_inst;
    assign data_data_ok = ret_vld & ~ret_inst;
    assign inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
    assign data_rdata   = (data_data_ok && !ret_store) ? mem_rdata : 32'h0;

    always_comb begin
        vld_d         = '0;
        own_inst_d    = '0;
        store_d       = '0;
        vld_d[0]      = grant_inst | grant_data;
        own_inst_d[0] = grant_inst;
        store_d[0]    = grant_data & data_wr;
        for (int i = 1; i < MEM_LAT; i++) begin
            vld_d[i]      = vld_q[i-1];
            own_inst_d[i] = own_inst_q[i-1];
            store_d[i]    = store_q[i-1];
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_inst) begin
            starve_cnt_d = '0;
        end else if (grant_data && inst_req && (starve_cnt_q != CW'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_q        <= '0;
            own_inst_q   <= '0;
            store_q      <= '0;
            starve_cnt_q <= '0;
        end else begin
            vld_q        <= vld_d;
            own_inst_q   <= own_inst_d;
            store_q      <= store_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: instance A (MEM_LAT=1) with an SRAM model, B (MEM_LAT=3) and
// C (MEM_LAT=2) sharing one stimulus set and a constant read-data source.
module tb_sram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A signals
    logic        a_resetn, a_inst_req, a_data_req, a_data_wr;
    logic [31:0] a_inst_addr, a_data_addr, a_data_wdata, a_mem_rdata;
    logic [3:0]  a_data_wstrb;
    logic        a_inst_addr_ok, a_inst_data_ok, a_data_addr_ok, a_data_data_ok, a_mem_en;
    logic [31:0] a_inst_rdata, a_data_rdata, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_wen;

    // Shared stimulus for B and C
    logic        b_resetn, b_inst_req, b_data_req, b_data_wr;
    logic [31:0] b_inst_addr, b_data_addr, b_data_wdata, b_mem_rdata;
    logic [3:0]  b_data_wstrb;
    logic        b_inst_addr_ok, b_inst_data_ok, b_data_addr_ok, b_data_data_ok, b_mem_en;
    logic [31:0] b_inst_rdata, b_data_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_wen;
    logic        c_inst_addr_ok, c_inst_data_ok, c_data_addr_ok, c_data_data_ok, c_mem_en;
    logic [31:0] c_inst_rdata, c_data_rdata, c_mem_addr, c_mem_wdata;
    logic [3:0]  c_mem_wen;

    sram_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_a (
        .clk(clk), .resetn(a_resetn),
        .inst_req(a_inst_req), .inst_addr(a_inst_addr), .inst_addr_ok(a_inst_addr_ok),
        .inst_data_ok(a_inst_data_ok), .inst_rdata(a_inst_rdata),
        .data_req(a_data_req), .data_wr(a_data_wr), .data_wstrb(a_data_wstrb),
        .data_addr(a_data_addr), .data_wdata(a_data_wdata), .data_addr_ok(a_data_addr_ok),
        .data_data_ok(a_data_data_ok), .data_rdata(a_data_rdata),
        .mem_en(a_mem_en), .mem_wen(a_mem_wen), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    sram_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_b (
        .clk(clk), .resetn(b_resetn),
        .inst_req(b_inst_req), .inst_addr(b_inst_addr), .inst_addr_ok(b_inst_addr_ok),
        .inst_data_ok(b_inst_data_ok), .inst_rdata(b_inst_rdata),
        .data_req(b_data_req), .data_wr(b_data_wr), .data_wstrb(b_data_wstrb),
        .data_addr(b_data_addr), .data_wdata(b_data_wdata), .data_addr_ok(b_data_addr_ok),
        .data_data_ok(b_data_data_ok), .data_rdata(b_data_rdata),
        .mem_en(b_mem_en), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    sram_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) u_c (
        .clk(clk), .resetn(b_resetn),
        .inst_req(b_inst_req), .inst_addr(b_inst_addr), .inst_addr_ok(c_inst_addr_ok),
        .inst_data_ok(c_inst_data_ok), .inst_rdata(c_inst_rdata),
        .data_req(b_data_req), .data_wr(b_data_wr), .data_wstrb(b_data_wstrb),
        .data_addr(b_data_addr), .data_wdata(b_data_wdata), .data_addr_ok(c_data_addr_ok),
        .data_data_ok(c_data_data_ok), .data_rdata(c_data_rdata),
        .mem_en(c_mem_en), .mem_wen(c_mem_wen), .mem_addr(c_mem_addr),
        .mem_wdata(c_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // One-cycle-latency byte-writable SRAM for instance A
    logic [31:0] mem_a [0:255];
    logic [31:0] a_rd_q;
    assign a_mem_rdata = a_rd_q;
    always @(posedge clk) begin
        if (a_mem_en) begin
            a_rd_q <= mem_a[a_mem_addr[9:2]];
            for (int b = 0; b < 4; b++) begin
                if (a_mem_wen[b]) mem_a[a_mem_addr[9:2]][b*8 +: 8] <= a_mem_wdata[b*8 +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_a[i] = 32'h0;
        mem_a[0]  = 32'h3C08BFC0;
        mem_a[1]  = 32'h25080010;
        mem_a[64] = 32'h11223344;

        a_resetn = 1'b0; a_inst_req = 1'b1; a_inst_addr = 32'hBFC00000;
        a_data_req = 1'b1; a_data_wr = 1'b0; a_data_wstrb = 4'h0;
        a_data_addr = 32'h100; a_data_wdata = 32'h0;
        b_resetn = 1'b0; b_inst_req = 1'b0; b_inst_addr = 32'h0;
        b_data_req = 1'b0; b_data_wr = 1'b0; b_data_wstrb = 4'h0;
        b_data_addr = 32'h0; b_data_wdata = 32'h0; b_mem_rdata = 32'hCAFE0001;

        // Reset held with both requests pending
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            check("rst_inst_addr_ok", a_inst_addr_ok, 1'b0);
            check("rst_data_addr_ok", a_data_addr_ok, 1'b0);
            check("rst_mem_en", a_mem_en, 1'b0);
            check("rst_mem_addr", a_mem_addr, 32'h0);
            check("rst_data_ok", {a_inst_data_ok, a_data_data_ok}, 2'b00);
        end
        a_resetn = 1'b1; #1;
        check("rel_data_addr_ok", a_data_addr_ok, 1'b1);
        check("rel_inst_addr_ok", a_inst_addr_ok, 1'b0);
        check("rel_mem_addr", a_mem_addr, 32'h100);

        // Load returns while first fetch is granted, then back-to-back fetch
        cyc(); a_data_req = 1'b0; #1;
        check("ld_data_ok", a_data_data_ok, 1'b1);
        check("ld_rdata", a_data_rdata, 32'h11223344);
        check("f0_addr_ok", a_inst_addr_ok, 1'b1);
        check("f0_mem_addr", a_mem_addr, 32'hBFC00000);
        cyc(); a_inst_addr = 32'hBFC00004; #1;
        check("f1_addr_ok", a_inst_addr_ok, 1'b1);
        check("f0_data_ok", a_inst_data_ok, 1'b1);
        check("f0_rdata", a_inst_rdata, 32'h3C08BFC0);
        check("f0_no_data_ok", a_data_data_ok, 1'b0);
        cyc(); a_inst_req = 1'b0; #1;
        check("f1_data_ok", a_inst_data_ok, 1'b1);
        check("f1_rdata", a_inst_rdata, 32'h25080010);
        check("idle_mem_en", a_mem_en, 1'b0);

        // Partial store, load back, zero-strobe store
        cyc();
        a_data_req = 1'b1; a_data_wr = 1'b1; a_data_wstrb = 4'b0011;
        a_data_addr = 32'h100; a_data_wdata = 32'hAABBCCDD; #1;
        check("st_addr_ok", a_data_addr_ok, 1'b1);
        check("st_mem_wen", a_mem_wen, 4'b0011);
        check("st_mem_wdata", a_mem_wdata, 32'hAABBCCDD);
        check("st_inst_data_ok", a_inst_data_ok, 1'b0);
        cyc(); a_data_wr = 1'b0; a_data_wstrb = 4'h0; #1;
        check("st_data_ok", a_data_data_ok, 1'b1);
        check("st_rdata", a_data_rdata, 32'h0);
        check("ld_mem_wen", a_mem_wen, 4'h0);
        check("ld_mem_wdata", a_mem_wdata, 32'h0);
        cyc(); a_data_wr = 1'b1; a_data_wstrb = 4'h0; a_data_wdata = 32'hFFFFFFFF; #1;
        check("ld2_data_ok", a_data_data_ok, 1'b1);
        check("ld2_rdata", a_data_rdata, 32'h1122CCDD);
        check("st0_mem_en", a_mem_en, 1'b1);
        check("st0_mem_wen", a_mem_wen, 4'h0);
        cyc(); a_data_wr = 1'b0; #1;
        check("st0_data_ok", a_data_data_ok, 1'b1);
        check("st0_rdata", a_data_rdata, 32'h0);
        cyc(); a_data_req = 1'b0; #1;
        check("ld3_rdata", a_data_rdata, 32'h1122CCDD);

        // Both requests held: D,D,D,D,I repeating
        cyc(); a_inst_req = 1'b1; a_inst_addr = 32'hBFC00000; a_data_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("starve_inst_ok", a_inst_addr_ok, (k % 5) == 4);
            check("starve_data_ok", a_data_addr_ok, (k % 5) != 4);
            cyc();
        end
        a_inst_req = 1'b0; a_data_req = 1'b0;

        // MEM_LAT=3: load then fetch
        cyc();
        b_resetn = 1'b1; b_data_req = 1'b1; b_data_addr = 32'h200;
        b_inst_req = 1'b1; b_inst_addr = 32'h300; #1;
        check("l3_data_addr_ok", b_data_addr_ok, 1'b1);
        check("l3_inst_blocked0", b_inst_addr_ok, 1'b0);
        check("l3_mem_addr", b_mem_addr, 32'h200);
        cyc(); b_data_req = 1'b0; #1;
        check("l3_inst_blocked1", b_inst_addr_ok, 1'b0);
        check("l3_mem_en_busy", b_mem_en, 1'b0);
        cyc(); #1;
        check("l3_inst_blocked2", b_inst_addr_ok, 1'b0);
        check("l3_no_early_ok", b_data_data_ok, 1'b0);
        cyc(); #1;
        check("l3_inst_addr_ok", b_inst_addr_ok, 1'b1);
        check("l3_inst_mem_addr", b_mem_addr, 32'h300);
        check("l3_data_ok", b_data_data_ok, 1'b1);
        check("l3_data_rdata", b_data_rdata, 32'hCAFE0001);
        check("l3_inst_ok_early", b_inst_data_ok, 1'b0);
        cyc(); b_inst_req = 1'b0; #1;
        check("l3_gap4", {b_inst_data_ok, b_data_data_ok}, 2'b00);
        cyc(); #1;
        check("l3_gap5", {b_inst_data_ok, b_data_data_ok}, 2'b00);
        cyc(); #1;
        check("l3_inst_data_ok", b_inst_data_ok, 1'b1);
        check("l3_inst_rdata", b_inst_rdata, 32'hCAFE0001);
        check("l3_data_ok_off", b_data_data_ok, 1'b0);

        // MEM_LAT=2: reset drops an in-flight load
        cyc(); b_data_req = 1'b1; b_data_addr = 32'h204; #1;
        check("l2_addr_ok", c_data_addr_ok, 1'b1);
        cyc(); b_data_req = 1'b0; b_resetn = 1'b0; #1;
        check("l2_rst_data_ok", c_data_data_ok, 1'b0);
        check("l2_rst_mem_en", c_mem_en, 1'b0);
        cyc(); b_resetn = 1'b1; #1;
        check("l2_dropped", c_data_data_ok, 1'b0);
        cyc(); #1;
        check("l2_dropped_late", c_data_data_ok, 1'b0);
        b_data_req = 1'b1; #1;
        check("l2_next_addr_ok", c_data_addr_ok, 1'b1);
        cyc(); b_data_req = 1'b0; #1;
        check("l2_next_wait", c_data_data_ok, 1'b0);
        cyc(); #1;
        check("l2_next_data_ok", c_data_data_ok, 1'b1);
        check("l2_next_rdata", c_data_rdata, 32'hCAFE0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
